mux_rr_arbiter: RTL
===================

# mux_rr_arbiter

Round-robin packet arbiter that shares one output channel among CHANNELS requesters and drives the select of the parametrized channel mux. It grants one requester at a time, locks the grant until that requester's last beat is accepted, and then rotates priority. It sits between the per-channel sources and the downstream consumer, with a valid/ready handshake on both sides.

## Interface
- WIDTH, 8, data width per channel
- CHANNELS, 4, number of requesters (≥2)
- MAX_BEATS, 16, beats after which a grant is force-released (≥1)
- SELW, clogb2(CHANNELS) with a minimum of 1, select width (derived, not overridden)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_bus  in  CHANNELS*WIDTH  channel data; channel k is bits [k*WIDTH +: WIDTH]
- in_valid  in  CHANNELS  per-channel valid / request
- in_last  in  CHANNELS  per-channel end-of-packet flag
- in_ready  out  CHANNELS  per-channel ready (one-hot or zero)
- out_data  out  WIDTH  muxed data
- out_valid  out  1  muxed valid
- out_last  out  1  muxed last
- out_ready  in  1  downstream ready
- grant  out  CHANNELS  one-hot registered grant
- sel  out  SELW  registered binary index of granted channel
- forced  out  1  one-cycle pulse on a MAX_BEATS forced release

## Operation
- FSM states: IDLE, BUSY.
- IDLE: grant=0, out_valid=0, in_ready=0. If any in_valid is high, pick the first requester strictly after ptr in circular order. Register grant/sel and go to BUSY. Otherwise stay in IDLE.
- BUSY:
  - out_data = in_bus[sel], out_valid = in_valid[sel], out_last = in_last[sel].
  - in_ready[sel] = out_ready; all other bits of in_ready are 0.
  - Beat accepted when out_valid & out_ready; beat_cnt increments on each accepted beat.
- Release: on an accepted beat with out_last=1, or when the accepted beat makes beat_cnt == MAX_BEATS. On release: ptr←sel, beat_cnt←0, go to IDLE.
- Forced release: pulse forced for one cycle (cycle after the release beat) and do not emit out_last. The remainder of the packet re-arbitrates like a new request.
- Granted requester drops in_valid mid-packet: stay in BUSY with out_valid=0 until it resumes. No timeout on idle cycles.
- Requests from non-granted channels are ignored during BUSY; they are neither acknowledged nor lost.
- beat_cnt width is clogb2(MAX_BEATS+1); it never wraps.
- Reset (any cycle, including mid-packet):
  - State: IDLE, grant=0, sel=0, beat_cnt=0, forced=0, ptr=CHANNELS-1 so channel 0 has first priority.
  - Outputs: out_valid=0, in_ready=0, out_data=in_bus[0] (don't-care while not valid), out_last=0.
  - A packet in progress is abandoned with no flush.

## Timing
- Arbitration latency: in_valid rising in IDLE at cycle N gives grant/sel at N+1, and the first beat can be accepted at N+1.
- Release at cycle M returns to IDLE at M+1. The earliest next grant is M+2, so there is one idle cycle between packets.
- Data path: out_data/out_valid/out_last and in_ready are combinational from registered sel plus inputs. No added latency.
- Simultaneous requests in IDLE: the lowest circular distance from ptr+1 wins.
- A single-beat packet (in_last on the first beat) occupies BUSY for one cycle if out_ready=1.

## Structure
- Shared package `mux_pkg` holds:
  - the clogb2 function (returns ≥1)
  - the state encoding constants ST_IDLE=0, ST_BUSY=1
- Sub-module `rr_pick`: combinational rotate-priority encoder. Inputs are req[CHANNELS] and ptr[SELW]; outputs are the one-hot winner, its index, and any.
- The top level holds the FSM, counters and the data mux.

## Test plan
- Reset: assert rst for 2 cycles mid-packet on ch2. Next cycle: grant=0, out_valid=0, in_ready=0000, sel=0. Then in_valid=1111 gives grant=0001.
- Rotation: all four channels send 1-beat packets continuously with out_ready=1. Grants go 0001,0010,0100,1000,0001, each two cycles apart.
- Locking: ch1 sends a 3-beat packet while ch3 requests. grant=0010 holds for all 3 beats; grant=1000 follows two cycles after ch1's last beat.
- Backpressure: ch2 is granted and out_ready toggles 0/1. in_ready[2] mirrors out_ready, and no beat is duplicated or dropped (compare 5-beat data 0xA0..0xA4).
- Forced release: MAX_BEATS=4 and ch0 sends 6 beats with no last. After beat 4: forced pulses once, out_last=0 throughout, and ch0 re-arbitrates for the remaining 2 beats.
- Granted source stall: ch1 is granted and drops in_valid for 5 cycles. Stays in BUSY, out_valid=0, ch2's request is ignored, and the packet completes on ch1.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared definitions for the round-robin packet arbiter: state encoding and
// the width helper used to size select and beat-counter fields.
package mux_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Number of bits needed to hold values 0..n-1, never less than one.
  function automatic int clogb2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: picks the first requester strictly after ptr in
// circular order and reports it as one-hot, as an index, and as "any".
module rr_pick
  import mux_pkg::*;
#(
  parameter int CHANNELS = 4,
  localparam int SELW = clogb2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SELW-1:0]     ptr,
  output logic [CHANNELS-1:0] win,
  output logic [SELW-1:0]     idx,
  output logic                any
);

  logic [SELW-1:0] k;

  // Scan from the farthest distance down so the nearest requester is the
  // last assignment and therefore the winner.
  always_comb begin
    win = '0;
    idx = '0;
    any = 1'b0;
    k   = '0;
    for (int d = CHANNELS; d >= 1; d--) begin
      k = SELW'((int'(ptr) + d) % CHANNELS);
      if (req[k]) begin
        win    = '0;
        win[k] = 1'b1;
        idx    = k;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin packet arbiter: locks one requester onto the shared output until
// its last beat (or MAX_BEATS beats) is accepted, then rotates priority.
module mux_rr_arbiter
  import mux_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CHANNELS  = 4,
  parameter int MAX_BEATS = 16,
  localparam int SELW = clogb2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_bus,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS-1:0]       in_last,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  output logic                      out_last,
  input  logic                      out_ready,
  output logic [CHANNELS-1:0]       grant,
  output logic [SELW-1:0]           sel,
  output logic                      forced
);

  localparam int CNTW = clogb2(MAX_BEATS + 1);

  state_e                state_q, state_d;
  logic [CHANNELS-1:0]   grant_q, grant_d;
  logic [SELW-1:0]       sel_q, sel_d;
  logic [SELW-1:0]       ptr_q, ptr_d;
  logic [CNTW-1:0]       cnt_q, cnt_d;
  logic                  forced_q, forced_d;

  logic [CHANNELS-1:0]   pick_win;
  logic [SELW-1:0]       pick_idx;
  logic                  pick_any;

  logic                  busy;
  logic                  beat_acc;
  logic                  last_acc;
  logic                  cap_hit;
  logic                  release_pkt;

  rr_pick #(
    .CHANNELS(CHANNELS)
  ) u_pick (
    .req(in_valid),
    .ptr(ptr_q),
    .win(pick_win),
    .idx(pick_idx),
    .any(pick_any)
  );

  assign busy        = (state_q == ST_BUSY);
  assign beat_acc    = busy && in_valid[sel_q] && out_ready;
  assign last_acc    = beat_acc && in_last[sel_q];
  assign cap_hit     = beat_acc && ((cnt_q + CNTW'(1)) == CNTW'(MAX_BEATS));
  assign release_pkt = last_acc || cap_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (pick_any)    state_d = ST_BUSY;
      ST_BUSY: if (release_pkt) state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // The data path is purely combinational from the registered select.
  always_comb begin
    out_data  = in_bus[int'(sel_q)*WIDTH +: WIDTH];
    out_valid = 1'b0;
    out_last  = 1'b0;
    in_ready  = '0;
    if (busy) begin
      out_valid       = in_valid[sel_q];
      out_last        = in_last[sel_q];
      in_ready[sel_q] = out_ready;
    end
  end

  always_comb begin
    grant_d  = grant_q;
    sel_d    = sel_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    forced_d = 1'b0;
    if (!busy) begin
      if (pick_any) begin
        grant_d = pick_win;
        sel_d   = pick_idx;
      end
    end else if (beat_acc) begin
      cnt_d = cnt_q + CNTW'(1);
      if (release_pkt) begin
        grant_d  = '0;
        ptr_d    = sel_q;
        cnt_d    = '0;
        // A beat carrying last ends the packet normally even at the cap.
        forced_d = cap_hit && !in_last[sel_q];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q  <= '0;
      sel_q    <= '0;
      ptr_q    <= SELW'(CHANNELS - 1);
      cnt_q    <= '0;
      forced_q <= 1'b0;
    end else begin
      grant_q  <= grant_d;
      sel_q    <= sel_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      forced_q <= forced_d;
    end
  end

  assign grant  = grant_q;
  assign sel    = sel_q;
  assign forced = forced_q;

endmodule
